// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector serial path.
// Holds the serializer FSM encoding and the default idle line level.
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/bit_serializer_tx_if.sv
// Word handshake into the serializer.
// The producer is the master; the serializer is the slave.
interface bit_serializer_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/ser_hold_buf.sv
// One-entry holding register with full flag.
// Written on accept while shifting, read on the drain edge.
module ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             ready
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      full  <= 1'b0;
    end else if (wr) begin
      rdata <= wdata;
      full  <= 1'b1;
    end else if (rd) begin
      full  <= 1'b0;
    end
  end

  assign ready = !full;

endmodule

// File: rtl/bit_serializer_tx.sv
// Parallel-to-serial front end feeding the 1010 detector.
// Streams words back-to-back through a one-word holding buffer.
module bit_serializer_tx
  import seq_det_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_serializer_tx_if.slave   s,
  output logic                 x,
  output logic                 x_valid,
  output logic                 word_done,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] hdata;
  logic [CW-1:0]    cnt;
  logic             hfull;
  logic             hrdy;
  logic             acc;
  logic             last;
  logic             head;

  assign s.in_ready = hrdy && !rst;
  assign acc        = s.in_valid && s.in_ready;
  assign last       = (state == SHIFT) && (cnt == LAST);
  assign head       = (MSB_FIRST != 0) ? sh[WIDTH-1] : sh[0];

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .wr    (acc && (state == SHIFT) && !last),
    .wdata (s.in_data),
    .rd    (last && hfull),
    .rdata (hdata),
    .full  (hfull),
    .ready (hrdy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            sh    <= s.in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last) begin
            sh  <= (MSB_FIRST != 0) ? (sh << 1) : (sh >> 1);
            cnt <= cnt + CW'(1);
          end else if (hfull) begin
            // buffered word wins; in_ready is low so no accept collides
            sh  <= hdata;
            cnt <= '0;
          end else if (acc) begin
            sh  <= s.in_data;
            cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign x         = (state == SHIFT) ? head : IDLE_BIT;
  assign x_valid   = (state == SHIFT);
  assign word_done = last;
  assign busy      = (state == SHIFT) || hfull;

endmodule

// File: tb/tb_bit_serializer_tx.sv
// Self-checking bench: vector table, hand sequences, random vs word-queue model.
// Runs an MSB-first and an LSB-first instance side by side.
module tb_bit_serializer_tx;
  import seq_det_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_serializer_tx_if #(.WIDTH(W)) bm ();
  bit_serializer_tx_if #(.WIDTH(W)) bl ();

  logic xm, xvm, wdm, bym;
  logic xl, xvl, wdl, byl;

  bit_serializer_tx #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .s(bm),
    .x(xm), .x_valid(xvm), .word_done(wdm), .busy(bym)
  );

  bit_serializer_tx #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .rst(rst), .s(bl),
    .x(xl), .x_valid(xvl), .word_done(wdl), .busy(byl)
  );

  int errs = 0;
  int checks = 0;

  // model: words in flight, front is on the line, mpos = bit index of front
  logic [W-1:0] mq[$];
  int mpos = 0;

  logic s_xm, s_xl, s_xv, s_wd, s_busy, s_rdy;
  logic [3:0] hist;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         ex;
    logic         exv;
    logic         ewd;
    logic         erdy;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    bm.in_valid = v;
    bm.in_data  = d;
    bl.in_valid = v;
    bl.in_data  = d;
  endtask

  task automatic step(input logic v, input logic [W-1:0] d);
    logic [W-1:0] w;
    logic ex_m, ex_l, exv, ewd, erdy;
    drive(v, d);
    exv  = (mq.size() > 0);
    erdy = (mq.size() <= 1);
    ex_m = 1'b0;
    ex_l = 1'b0;
    ewd  = 1'b0;
    if (exv) begin
      w    = mq[0];
      ex_m = w[W-1-mpos];
      ex_l = w[mpos];
      ewd  = (mpos == W - 1);
    end
    @(negedge clk);
    s_xm = xm; s_xl = xl; s_xv = xvm;
    s_wd = wdm; s_busy = bym; s_rdy = bm.in_ready;
    hist = {hist[2:0], xm};
    chk("x_msb", xm, ex_m);
    chk("x_lsb", xl, ex_l);
    chk("x_valid", xvm, exv);
    chk("x_valid_l", xvl, exv);
    chk("word_done", wdm, ewd);
    chk("word_done_l", wdl, ewd);
    chk("busy", bym, exv);
    chk("in_ready", bm.in_ready, erdy);
    chk("in_ready_l", bl.in_ready, erdy);
    @(posedge clk);
    if (exv) begin
      mpos++;
      if (mpos == W) begin
        mpos = 0;
        void'(mq.pop_front());
      end
    end
    if (v && erdy) mq.push_back(d);
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    mpos = 0;
  endtask

  initial begin
    logic [15:0] serial;
    logic [7:0]  lsbv;
    logic        rdy_all;

    rst = 1'b1;
    drive(1'b0, '0);
    hist = '0;
    model_clear();

    // 0xA5 MSB-first vectors
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_x", xm, 1'b0);
    chk("rst_x_valid", xvm, 1'b0);
    chk("rst_word_done", wdm, 1'b0);
    chk("rst_busy", bym, 1'b0);
    chk("rst_in_ready", bm.in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rel_in_ready", bm.in_ready, 1'b1);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d);
      chk("tbl_x", s_xm, tbl[i].ex);
      chk("tbl_x_valid", s_xv, tbl[i].exv);
      chk("tbl_word_done", s_wd, tbl[i].ewd);
      chk("tbl_in_ready", s_rdy, tbl[i].erdy);
    end

    // 0xAA then 0x55 with valid held until ready returns
    serial = '0;
    for (int n = 0; n < 19; n++) begin
      if (n == 0) step(1'b1, 8'hAA);
      else if (n <= 8) step(1'b1, 8'h55);
      else step(1'b0, 8'h00);
      if (s_xv) serial = {serial[14:0], s_xm};
      if (n <= 10) chk("b2b_in_ready", s_rdy, (n >= 2 && n <= 8) ? 1'b0 : 1'b1);
      if (n >= 1 && n <= 16) chk("b2b_contig", s_xv, 1'b1);
    end
    chk("b2b_bits", serial, 16'b1010101001010101);
    chk("b2b_idle", s_xv, 1'b0);

    // LSB-first 0x0A
    lsbv = '0;
    step(1'b1, 8'h0A);
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 8'h00);
      lsbv = {lsbv[6:0], s_xl};
    end
    chk("lsb_bits", lsbv, 8'b01010000);
    step(1'b0, 8'h00);

    // bypass: second word offered only in the last-bit cycle
    rdy_all = 1'b1;
    step(1'b1, 8'h3C);
    for (int n = 1; n < 18; n++) begin
      if (n == 8) step(1'b1, 8'hC3);
      else step(1'b0, 8'hFF);
      rdy_all &= s_rdy;
      if (n == 9) chk("bypass_first_bit", s_xm, 1'b1);
      if (n == 16) chk("bypass_done", s_wd, 1'b1);
    end
    chk("bypass_no_hold", rdy_all, 1'b1);

    // reset during bit 3 of 0xFF
    step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("pre_rst_x", xm, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_x", xm, 1'b0);
    chk("mid_rst_x_valid", xvm, 1'b0);
    chk("mid_rst_in_ready", bm.in_ready, 1'b0);
    chk("mid_rst_busy", bym, 1'b0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 10; n++) step(1'b0, 8'h00);

    // idle for 20 cycles with garbage on in_data
    hist = '0;
    for (int n = 0; n < 20; n++) begin
      step(1'b0, W'($urandom));
      chk("idle_x", s_xm, 1'b0);
      chk("idle_busy", s_busy, 1'b0);
      chk("idle_det", (hist == 4'b1010), 1'b0);
    end

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 60, W'($urandom));
    end
    for (int n = 0; n < 2 * W + 4; n++) step(1'b0, 8'h00);
    chk("drain_empty", s_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bit_serializer_tx.md
# bit_serializer_tx

Parallel-to-serial front end for the sequence-detector path. Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on `x`, the single-bit serial input consumed directly by the downstream 1010 detector. A one-word holding buffer lets back-to-back words stream with no idle gap between them. When no word is available, the block drives a fixed idle level.

## Interface
- `WIDTH`, 8: word width in bits, ≥2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- `IDLE_BIT`, 0: level driven on `x` when no word is being sent.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  word to serialize.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `x`  out  1  serial bit to the detector.
- `x_valid`  out  1  `x` carries a word bit, not idle fill.
- `word_done`  out  1  high during the last bit of a word.
- `busy`  out  1  a word is shifting or buffered.

## Operation
- Internal state:
  - shift register `sh` (WIDTH)
  - bit counter `cnt` (clog2(WIDTH))
  - holding register `hold` with flag `hold_full`
  - FSM with states IDLE and SHIFT
- Accept occurs when `in_valid && in_ready` at a rising edge.
- `in_ready` = !`hold_full`. It is forced to 0 while `rst` is high.
- **IDLE**
  - On accept: load `in_data` into `sh`, set `cnt`=0, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT, `cnt` < WIDTH-1**
  - Each edge: shift `sh` toward the output end and increment `cnt`.
  - An accept this edge writes `hold` and sets `hold_full`.
- **SHIFT, `cnt` == WIDTH-1 (last bit)**
  - If `hold_full`: load `sh` from `hold`, clear `hold_full`, set `cnt`=0, stay in SHIFT.
  - Else, on an accept this edge (bypass): load `sh` from `in_data`, set `cnt`=0, stay in SHIFT.
  - Otherwise go to IDLE.
- Outputs:
  - `x` = head bit of `sh` in SHIFT (MSB or LSB per `MSB_FIRST`); `x` = `IDLE_BIT` in IDLE.
  - `x_valid` = (state == SHIFT).
  - `word_done` = SHIFT && `cnt` == WIDTH-1.
  - `busy` = SHIFT || `hold_full`.
- Width rules:
  - `cnt` compares against WIDTH-1 exactly; no wrap beyond it.
  - `in_data` is captured whole; no partial words.
- Idle fill of 0 guarantees that the detector never sees a spurious 1 between words.

## Timing
- Reset values: state IDLE, `sh`=0, `cnt`=0, `hold_full`=0, `x`=`IDLE_BIT`, `x_valid`=0, `word_done`=0, `busy`=0. `in_ready` is 0 while `rst` is high and 1 after release.
- Latency: for a word accepted at edge k, bit i appears on `x` during cycle k+1+i (i = 0..WIDTH-1). `word_done` is high during cycle k+WIDTH.
- Back-to-back words: the first bit of the next word appears in cycle k+WIDTH+1 with no gap.
- `in_ready` is low from the edge after `hold` fills until the last-bit edge that drains it.
- Hold full at the last bit: `hold` drains into `sh`. `in_ready` is 0 in that cycle, so there is no simultaneous accept.
- Reset mid-word: everything returns to reset values immediately. Partial and buffered words are discarded; no further bits are emitted.
- `in_data` may change freely when not accepted.

## Structure
- Shared package `seq_det_pkg` contains:
  - FSM state typedef (IDLE, SHIFT)
  - `IDLE_BIT` default constant
- One sub-module: `ser_hold_buf`, the one-entry holding register with full flag, write on accept, read on the drain edge, and `ready` = !full.
- Top level contains the FSM, counter and shift register.

## Test plan
- Reset, then `in_data`=0xA5 (`MSB_FIRST`=1) accepted at edge k → `x` = 1,0,1,0,0,1,0,1 in cycles k+1..k+8; `x_valid` high for exactly those 8 cycles; `word_done` high only at k+8; `x`=0 afterwards.
- 0xAA then 0x55 with `in_valid` held high → 16 contiguous valid bits 1010101001010101; `in_ready` low in cycles k+2..k+8 and high again at k+9.
- `MSB_FIRST`=0, word 0x0A → `x` = 0,1,0,1,0,0,0,0.
- Bypass: first word accepted; second word presented only in its last-bit cycle → second word starts in the next cycle, `hold_full` never set.
- Assert `rst` during bit 3 of 0xFF → `x`=0, `x_valid`=0 and `in_ready`=0 immediately; after release, `in_ready`=1 and no residual bits are emitted.
- No `in_valid` for 20 cycles → `x`=`IDLE_BIT`, `busy`=0, and the downstream detector output stays 0.
